// File: rtl/mem_bus_arbiter.sv
// Arbitrates one Avalon-style single-port memory bus between the instruction-fetch
// and data-access requesters. Serialises transactions, holds per-port read data
// and raises a sticky error when the bus stalls for too long.
module mem_bus_arbiter #(
    parameter int unsigned ARB_MODE       = 0,     // 0: round-robin, 1: data has priority
    parameter int unsigned TIMEOUT_CYCLES = 1024   // 1..65535
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,

    output logic        bus_error
);

    typedef enum logic [2:0] {StIdle, StXferI, StXferD, StDoneI, StDoneD} state_e;

    // Last wait cycle allowed before the transaction is aborted.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 0: instruction, 1: data
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        error_q, error_d;

    logic d_req, i_req, grant_data;

    assign d_req = d_read | d_write;
    assign i_req = i_read;
    // Data wins when alone, under fixed priority, or when instruction was served last.
    assign grant_data = d_req & (~i_req | (ARB_MODE == 1) | ~last_grant_q);

    // Next-state and registered bus outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = '0;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        error_d      = error_q;

        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    address_d    = d_address;
                    byteenable_d = d_byteenable;
                    writedata_d  = d_writedata;
                    write_d      = d_write;
                    read_d       = ~d_write;  // read+write together is a write
                    last_grant_d = 1'b1;
                    state_d      = StXferD;
                end else if (i_req) begin
                    address_d    = i_address;
                    byteenable_d = 4'hF;
                    write_d      = 1'b0;
                    read_d       = 1'b1;
                    last_grant_d = 1'b0;
                    state_d      = StXferI;
                end
            end
            StXferI, StXferD: begin
                if (!avm_waitrequest) begin
                    if (read_q) begin
                        if (state_q == StXferD) d_rdata_d = avm_readdata;
                        else                    i_rdata_d = avm_readdata;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = (state_q == StXferD) ? StDoneD : StDoneI;
                end else if (cnt_q == TimeoutLast) begin
                    // Abort but still complete the request so the CPU never hangs.
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    error_d = 1'b1;
                    state_d = (state_q == StXferD) ? StDoneD : StDoneI;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDoneI, StDoneD: state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            error_q      <= error_d;
        end
    end

    assign avm_address    = address_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = writedata_q;
    assign avm_byteenable = byteenable_q;
    assign i_readdata     = i_rdata_q;
    assign d_readdata     = d_rdata_q;
    assign bus_error      = error_q;

    // Requester stalls release only in that port's completion cycle.
    assign i_waitrequest = i_read & (state_q != StDoneI);
    assign d_waitrequest = d_req & (state_q != StDoneD);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin instance (dut0) and one
// fixed-priority instance (dut1) share all inputs; each phase checks one of them.
module tb_mem_bus_arbiter;

    logic        clk, rst;
    logic [31:0] i_address, d_address, d_writedata, avm_readdata;
    logic        i_read, d_read, d_write, avm_waitrequest;
    logic [3:0]  d_byteenable;

    logic [31:0] i_readdata, d_readdata, avm_address, avm_writedata;
    logic        i_waitrequest, d_waitrequest, avm_read, avm_write, bus_error;
    logic [3:0]  avm_byteenable;

    logic [31:0] m1_i_readdata, m1_d_readdata, m1_avm_address, m1_avm_writedata;
    logic        m1_i_waitrequest, m1_d_waitrequest, m1_avm_read, m1_avm_write, m1_bus_error;
    logic [3:0]  m1_avm_byteenable;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .bus_error(bus_error)
    );

    mem_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_readdata(m1_i_readdata),
        .i_waitrequest(m1_i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(m1_d_readdata), .d_waitrequest(m1_d_waitrequest),
        .avm_address(m1_avm_address), .avm_read(m1_avm_read), .avm_write(m1_avm_write),
        .avm_writedata(m1_avm_writedata), .avm_byteenable(m1_avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .bus_error(m1_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge; inputs change and checks happen here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; avm_waitrequest = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    int hi, lo, rd, n_d, n_i, iw;

    initial begin
        rst = 1'b1;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_avm_read", avm_read, 0);
        check_eq("rst_avm_write", avm_write, 0);
        check_eq("rst_avm_address", avm_address, 0);
        check_eq("rst_avm_be", avm_byteenable, 0);
        check_eq("rst_bus_error", bus_error, 0);
        check_eq("rst_i_readdata", i_readdata, 0);
        check_eq("rst_d_readdata", d_readdata, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Single zero-wait fetch.
        cyc();
        i_read = 1'b1; i_address = 32'hBFC0_0000; avm_readdata = 32'h2402_0005;
        #1 check_eq("f_idle_iwait", i_waitrequest, 1);
        check_eq("f_idle_read", avm_read, 0);
        cyc(); #1;
        check_eq("f_xfer_read", avm_read, 1);
        check_eq("f_xfer_addr", avm_address, 32'hBFC0_0000);
        check_eq("f_xfer_be", avm_byteenable, 4'hF);
        check_eq("f_xfer_iwait", i_waitrequest, 1);
        cyc(); #1;
        check_eq("f_done_read", avm_read, 0);
        check_eq("f_done_iwait", i_waitrequest, 0);
        check_eq("f_done_rdata", i_readdata, 32'h2402_0005);
        cyc();
        i_read = 1'b0; avm_readdata = 32'h0;
        #1 check_eq("f_noreq_iwait", i_waitrequest, 0);
        cyc(); #1;
        check_eq("f_hold_rdata", i_readdata, 32'h2402_0005);
        check_eq("f_idle_read2", avm_read, 0);

        // Round-robin: simultaneous fetch and write from reset, data first.
        pulse_reset();
        cyc();
        i_read = 1'b1; i_address = 32'h100;
        d_write = 1'b1; d_address = 32'h10; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        avm_readdata = 32'hCAFE_F00D;
        #1 check_eq("rr_idle_iwait", i_waitrequest, 1);
        check_eq("rr_idle_dwait", d_waitrequest, 1);
        cyc(); #1;
        check_eq("rr_d_write", avm_write, 1);
        check_eq("rr_d_read", avm_read, 0);
        check_eq("rr_d_addr", avm_address, 32'h10);
        check_eq("rr_d_wdata", avm_writedata, 32'hDEAD_BEEF);
        check_eq("rr_d_be", avm_byteenable, 4'b0011);
        check_eq("rr_d_iwait", i_waitrequest, 1);
        cyc(); #1;
        check_eq("rr_ddone_write", avm_write, 0);
        check_eq("rr_ddone_dwait", d_waitrequest, 0);
        check_eq("rr_ddone_iwait", i_waitrequest, 1);
        cyc();
        d_write = 1'b0;
        #1 check_eq("rr_idle2_iwait", i_waitrequest, 1);
        check_eq("rr_idle2_read", avm_read, 0);
        cyc(); #1;
        check_eq("rr_i_read", avm_read, 1);
        check_eq("rr_i_addr", avm_address, 32'h100);
        check_eq("rr_i_be", avm_byteenable, 4'hF);
        cyc(); #1;
        check_eq("rr_idone_iwait", i_waitrequest, 0);
        check_eq("rr_idone_rdata", i_readdata, 32'hCAFE_F00D);
        check_eq("rr_write_no_drdata", d_readdata, 0);
        cyc();
        i_read = 1'b0;
        d_write = 1'b1; d_address = 32'h14;
        cyc(); cyc(); cyc();
        // Data was served last, so the next simultaneous pair favours instruction.
        d_write = 1'b0;
        i_read = 1'b1; i_address = 32'h104; d_read = 1'b1; d_address = 32'h18;
        avm_readdata = 32'h1111_2222;
        cyc(); #1;
        check_eq("rr2_i_first_addr", avm_address, 32'h104);
        check_eq("rr2_i_first_read", avm_read, 1);
        check_eq("rr2_dwait", d_waitrequest, 1);
        cyc(); #1;
        check_eq("rr2_idone_rdata", i_readdata, 32'h1111_2222);
        cyc();
        i_read = 1'b0; avm_readdata = 32'h3333_4444;
        cyc(); #1;
        check_eq("rr2_d_addr", avm_address, 32'h18);
        check_eq("rr2_d_read", avm_read, 1);
        cyc(); #1;
        check_eq("rr2_ddone_dwait", d_waitrequest, 0);
        check_eq("rr2_ddone_rdata", d_readdata, 32'h3333_4444);
        cyc();
        d_read = 1'b0;

        // Five bus wait states on a data read.
        d_read = 1'b1; d_address = 32'h20; avm_waitrequest = 1'b1; avm_readdata = 32'h1234_5678;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            if (i == 6) avm_waitrequest = 1'b0;
            #1;
            if (i < 7 && d_waitrequest) hi++;
        end
        check_eq("ws_dwait_high", 32'(hi), 7);
        check_eq("ws_dwait_low", d_waitrequest, 0);
        check_eq("ws_rdata", d_readdata, 32'h1234_5678);
        check_eq("ws_no_error", bus_error, 0);
        cyc();
        d_read = 1'b0;

        // Stuck bus on a fetch aborts after eight wait cycles.
        i_read = 1'b1; i_address = 32'h200; avm_waitrequest = 1'b1; avm_readdata = 32'h55AA_55AA;
        rd = 0; lo = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            #1;
            if (avm_read) rd++;
            if (!i_waitrequest) lo++;
            if (i == 8) check_eq("to_err_before", bus_error, 0);
        end
        check_eq("to_read_cycles", 32'(rd), 8);
        check_eq("to_iwait_pulses", 32'(lo), 1);
        check_eq("to_iwait_done", i_waitrequest, 0);
        check_eq("to_error", bus_error, 1);
        check_eq("to_rdata_kept", i_readdata, 32'h1111_2222);
        cyc();
        i_read = 1'b0; avm_waitrequest = 1'b0;
        d_read = 1'b1; d_address = 32'h24; avm_readdata = 32'h7777_8888;
        cyc(); cyc(); #1;
        check_eq("sticky_rdata", d_readdata, 32'h7777_8888);
        check_eq("sticky_error", bus_error, 1);
        cyc();
        d_read = 1'b0;

        // Fixed data priority on the second instance.
        pulse_reset();
        cyc();
        d_read = 1'b1; d_address = 32'h40; i_read = 1'b1; i_address = 32'h200; avm_readdata = '0;
        n_d = 0; n_i = 0; iw = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            #1;
            if (m1_avm_read && m1_avm_address == 32'h40) n_d++;
            if (m1_avm_read && m1_avm_address == 32'h200) n_i++;
            if (m1_i_waitrequest) iw++;
        end
        check_eq("pri_d_grants", 32'(n_d), 3);
        check_eq("pri_i_grants", 32'(n_i), 0);
        check_eq("pri_i_stalled", 32'(iw), 9);
        cyc();
        d_read = 1'b0;
        #1 check_eq("pri_idle_read", m1_avm_read, 0);
        cyc(); #1;
        check_eq("pri_i_read", m1_avm_read, 1);
        check_eq("pri_i_addr", m1_avm_address, 32'h200);
        cyc(); #1;
        check_eq("pri_i_done", m1_i_waitrequest, 0);
        cyc();
        i_read = 1'b0;

        // Asynchronous reset in the middle of a data write.
        d_write = 1'b1; d_address = 32'h30; d_writedata = 32'hA5A5_A5A5; d_byteenable = 4'hF;
        avm_waitrequest = 1'b1;
        cyc(); #1;
        check_eq("ar_write_before", avm_write, 1);
        rst = 1'b0;
        #1;
        check_eq("ar_write", avm_write, 0);
        check_eq("ar_addr", avm_address, 0);
        check_eq("ar_wdata", avm_writedata, 0);
        check_eq("ar_be", avm_byteenable, 0);
        check_eq("ar_error", bus_error, 0);
        check_eq("ar_i_rdata", i_readdata, 0);
        check_eq("ar_d_rdata", d_readdata, 0);
        d_write = 1'b0; avm_waitrequest = 1'b0;
        #1 rst = 1'b1;
        cyc();
        i_read = 1'b1; i_address = 32'h300; d_read = 1'b1; d_address = 32'h50;
        #1 check_eq("ar_idle_dwait", d_waitrequest, 1);
        cyc(); #1;
        check_eq("ar_regrant_read", avm_read, 1);
        check_eq("ar_regrant_addr", avm_address, 32'h50);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one Avalon-style single-port memory bus between the CPU instruction-fetch requester and the data-access requester.
- Gives each requester its own waitrequest, which the CPU uses as a stall.
- Sits between the CPU core and the unified memory/bus-bridge.
- Serialises transactions, holds returned read data per port, and flags bus hangs via a timeout.

Parameters:
- ARB_MODE, 0, 0 = round-robin on simultaneous requests; 1 = fixed data-port priority
- TIMEOUT_CYCLES, 1024, cycles avm_waitrequest may stay high before the transaction is aborted (1..65535)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_address  input  32  instruction fetch address
- i_read  input  1  fetch request
- i_readdata  output  32  fetched word; held until the next instruction completion
- i_waitrequest  output  1  high = instruction port stalled
- d_address  input  32  data address
- d_read  input  1  data read request
- d_write  input  1  data write request
- d_writedata  input  32  write data
- d_byteenable  input  4  byte lanes
- d_readdata  output  32  read word; held until the next data read completion
- d_waitrequest  output  1  high = data port stalled
- avm_address  output  32  bus address
- avm_read  output  1  bus read strobe
- avm_write  output  1  bus write strobe
- avm_writedata  output  32  bus write data
- avm_byteenable  output  4  bus byte lanes (4'hF for fetches)
- avm_readdata  input  32  bus read data, valid when avm_waitrequest=0
- avm_waitrequest  input  1  bus stall
- bus_error  output  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all avm_* outputs, i_readdata, d_readdata and bus_error go to 0.
  - last_grant=INSTR; timeout counter=0.
  - Any in-flight bus transaction is abandoned.
- FSM states: IDLE, XFER_I, XFER_D, DONE_I, DONE_D.
- IDLE:
  - Data request: d_read|d_write. Instruction request: i_read.
  - If only one request is present, grant it.
  - If both are present:
    - ARB_MODE=1: grant data.
    - ARB_MODE=0: grant the port opposite last_grant.
  - On grant, register avm_address/byteenable/writedata/strobes from the granted port; last_grant<=granted; go to XFER_x.
  - d_write=1 with d_read=1 is treated as a write.
- XFER_x:
  - avm_* held constant.
  - At an edge with avm_waitrequest=0:
    - For reads, capture avm_readdata into that port's readdata register.
    - Drop avm strobes; go to DONE_x.
  - Timeout counter increments each XFER cycle with avm_waitrequest=1. When it reaches TIMEOUT_CYCLES:
    - Drop strobes; set bus_error.
    - Leave readdata unchanged; go to DONE_x, completing the request so the CPU does not hang.
  - Counter clears on leaving XFER.
- DONE_x:
  - One cycle; avm strobes=0; go to IDLE.
  - A new grant is possible on the following cycle.
- Requester waitrequest (combinational):
  - i_waitrequest = i_read & (state!=DONE_I).
  - d_waitrequest = (d_read|d_write) & (state!=DONE_D).
  - No request means waitrequest is 0.
- Latency: with a zero-wait bus a transaction takes 3 cycles from request (IDLE, XFER, DONE). Each extra avm_waitrequest cycle adds one.
- Requesters hold address/data/strobes constant while waitrequest=1.
  - If a request is dropped during XFER, the bus transaction still completes.
  - For a dropped read, data is still captured; the DONE cycle has no effect on waitrequest.
- A write never updates d_readdata.
- Readdata outputs hold their value indefinitely between completions.
- No combinational path from avm_* inputs to avm_* outputs.

Test Plan:
- Single fetch, zero-wait bus, i_read=1 at 32'hBFC00000, avm_readdata=32'h24020005 → avm_read high for 1 cycle with avm_byteenable=4'hF; i_waitrequest low in 3rd cycle; i_readdata=32'h24020005 and held after i_read drops.
- Simultaneous i_read and d_write (addr 32'h10, data 32'hDEADBEEF, be 4'b0011), ARB_MODE=0, fresh from reset → data granted first (avm_write, be 4'b0011); instruction granted next; total 6 cycles; second pair of simultaneous requests grants instruction first.
- ARB_MODE=1 with continuous d_read and i_read → data granted every transaction; instruction waits until d_read deasserts.
- avm_waitrequest held high for 5 cycles on d_read at 32'h20 returning 32'h12345678 → d_waitrequest high for 7 cycles, then low for 1; d_readdata=32'h12345678; bus_error stays 0.
- TIMEOUT_CYCLES=8, avm_waitrequest stuck high on i_read → strobes drop after 8 wait cycles; bus_error=1 (sticky); i_waitrequest pulses low once; i_readdata unchanged.
- rst asserted low mid-XFER_D → avm_write and all outputs go to 0 immediately without a clock; after release, next request arbitrates from IDLE with last_grant=INSTR.
